// File: rtl/cmp_rr_arbiter.sv
// Round-robin shared unsigned magnitude comparator with a registered result slot.
// Latency 1 cycle from accept; accepts only when the slot is empty or draining. Optional counters: CMP_STATS_EN.
module cmp_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int W      = 4,
    parameter int IDW    = 2,
    parameter int STAT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic                res_alb,
    output logic                res_aeb,
    output logic                res_agb
`ifdef CMP_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [STAT_W-1:0]   stat_lt,
    output logic [STAT_W-1:0]   stat_eq,
    output logic [STAT_W-1:0]   stat_gt
`endif
);

    if (STAT_W < 1 || IDW < $clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
        $error("cmp_rr_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             alb_q, alb_d, aeb_q, aeb_d, agb_q, agb_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic             win_ok;
    logic             accept;
    logic [W-1:0]     op_a, op_b;

    // Gating with rst_n keeps req_ready low for the whole reset interval.
    assign win_ok = rst_n && ((state_q == IDLE) || res_ready);

    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                gidx       = idx[IDW-1:0];
                grant[idx] = 1'b1;
            end
        end
        accept    = found && win_ok;
        req_ready = accept ? grant : '0;
        op_a      = req_a[int'(gidx)*W +: W];
        op_b      = req_b[int'(gidx)*W +: W];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        res_id_d = res_id_q;
        alb_d    = alb_q;
        aeb_d    = aeb_q;
        agb_d    = agb_q;
        if (accept) begin
            state_d  = FULL;
            rr_ptr_d = IDW'((int'(gidx) + 1) % NREQ);
            res_id_d = gidx;
            alb_d    = (op_a <  op_b);
            aeb_d    = (op_a == op_b);
            agb_d    = (op_a >  op_b);
        end else if (state_q == FULL && res_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            res_id_q <= '0;
            alb_q    <= 1'b0;
            aeb_q    <= 1'b0;
            agb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            res_id_q <= res_id_d;
            alb_q    <= alb_d;
            aeb_q    <= aeb_d;
            agb_q    <= agb_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_id    = res_id_q;
    assign res_alb   = alb_q;
    assign res_aeb   = aeb_q;
    assign res_agb   = agb_q;

`ifdef CMP_STATS_EN
    logic [STAT_W-1:0] lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        lt_d = lt_q;
        eq_d = eq_q;
        gt_d = gt_q;
        if (stat_clr) begin
            lt_d = '0;
            eq_d = '0;
            gt_d = '0;
        end else if (accept) begin
            if (alb_d && lt_q != '1) lt_d = lt_q + STAT_W'(1);
            if (aeb_d && eq_q != '1) eq_d = eq_q + STAT_W'(1);
            if (agb_d && gt_q != '1) gt_d = gt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q <= '0;
            eq_q <= '0;
            gt_q <= '0;
        end else begin
            lt_q <= lt_d;
            eq_q <= eq_d;
            gt_q <= gt_d;
        end
    end

    assign stat_lt = lt_q;
    assign stat_eq = eq_q;
    assign stat_gt = gt_q;
`endif

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Directed bench for cmp_rr_arbiter: reset, single grant, back-to-back, rotation, backpressure, mid-run reset.
module tb_cmp_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
`ifdef CMP_STATS_EN
    localparam int STAT_W = 2;
`else
    localparam int STAT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              res_valid, res_ready;
    logic [IDW-1:0]    res_id;
    logic              res_alb, res_aeb, res_agb;
`ifdef CMP_STATS_EN
    logic              stat_clr;
    logic [STAT_W-1:0] stat_lt, stat_eq, stat_gt;
`endif

    int checks = 0;
    int failures = 0;

    cmp_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_alb(res_alb), .res_aeb(res_aeb), .res_agb(res_agb)
`ifdef CMP_STATS_EN
        , .stat_clr(stat_clr), .stat_lt(stat_lt), .stat_eq(stat_eq), .stat_gt(stat_gt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b1; req_a = '0; req_b = '0;
`ifdef CMP_STATS_EN
        stat_clr = 1'b0;
`endif
        #2;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", res_id); end
        checks++; if ({res_alb, res_aeb, res_agb} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {res_alb, res_aeb, res_agb}); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready_edge got=%b exp=0000", req_ready); end
        req_valid = '0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0001; res_ready = 1'b1; set_ops(0, 10, 12);
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", res_valid); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", res_id); end
        checks++; if ({res_alb, res_aeb, res_agb} !== 3'b100) begin failures++; $display("FAIL single_flags got=%b exp=100", {res_alb, res_aeb, res_agb}); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b0110; res_ready = 1'b1; set_ops(1, 15, 11); set_ops(2, 10, 10);
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL b2b_ready1 got=%b exp=0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || {res_alb, res_aeb, res_agb} !== 3'b001) begin
            failures++; $display("FAIL b2b_res1 got=v%b id%0d f%b exp=v1 id1 f001", res_valid, res_id, {res_alb, res_aeb, res_agb}); end
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL b2b_ready2 got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || {res_alb, res_aeb, res_agb} !== 3'b010) begin
            failures++; $display("FAIL b2b_res2 got=v%b id%0d f%b exp=v1 id2 f010", res_valid, res_id, {res_alb, res_aeb, res_agb}); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [2:0] exp_f;
        do_reset();
        // Requester i compares i against 2: 0,1 -> lt, 2 -> eq, 3 -> gt.
        for (int i = 0; i < NREQ; i++) set_ops(i, i, 2);
        req_valid = 4'hF; res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            exp_f = ((k % 4) < 2) ? 3'b100 : (((k % 4) == 2) ? 3'b010 : 3'b001);
            #1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
            tick();
            if (k == 7) req_valid = 4'h0;
            checks++; if (res_id !== IDW'(k % 4) || {res_alb, res_aeb, res_agb} !== exp_f) begin
                failures++; $display("FAIL rr_res[%0d] got=id%0d f%b exp=id%0d f%b", k, res_id, {res_alb, res_aeb, res_agb}, k % 4, exp_f); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1000; res_ready = 1'b1; set_ops(3, 7, 3);
        tick();
        res_ready = 1'b0; set_ops(3, 2, 9);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || {res_alb, res_aeb, res_agb} !== 3'b001) begin
                failures++; $display("FAIL bp_hold[%0d] got=v%b id%0d f%b exp=v1 id3 f001", k, res_valid, res_id, {res_alb, res_aeb, res_agb}); end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release got=%b exp=1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || {res_alb, res_aeb, res_agb} !== 3'b100) begin
            failures++; $display("FAIL bp_res got=v%b id%0d f%b exp=v1 id3 f100", res_valid, res_id, {res_alb, res_aeb, res_agb}); end
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100; res_ready = 1'b0; set_ops(2, 0, 15);
        tick();
        req_valid = 4'hF;
        checks++; if (res_valid !== 1'b1 || res_alb !== 1'b1) begin failures++; $display("FAIL mid_full got=v%b lt%b exp=v1 lt1", res_valid, res_alb); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || res_id !== 2'd0 || {res_alb, res_aeb, res_agb} !== 3'b000) begin
            failures++; $display("FAIL mid_async got=v%b id%0d f%b exp=v0 id0 f000", res_valid, res_id, {res_alb, res_aeb, res_agb}); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_rst got=%b exp=0000", req_ready); end
        tick();
        rst_n = 1'b1; res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'h0;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin failures++; $display("FAIL mid_res got=v%b id%0d exp=v1 id0", res_valid, res_id); end
        tick();
    endtask

`ifdef CMP_STATS_EN
    task automatic test_stats();
        do_reset();
        stat_clr = 1'b0; req_valid = 4'b0001; res_ready = 1'b1; set_ops(0, 1, 5);
        for (int k = 0; k < 4; k++) tick();
        checks++; if (stat_lt !== 2'd3) begin failures++; $display("FAIL stat_sat got=%0d exp=3", stat_lt); end
        set_ops(0, 5, 5); stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0; req_valid = 4'b0000;
        checks++; if (res_aeb !== 1'b1) begin failures++; $display("FAIL stat_eq_res got=%b exp=1", res_aeb); end
        checks++; if ({stat_lt, stat_eq, stat_gt} !== 6'd0) begin failures++; $display("FAIL stat_clr got=%0d/%0d/%0d exp=0/0/0", stat_lt, stat_eq, stat_gt); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef CMP_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
